// File: rtl/axis_id_unpacker_pkg.sv
// ----------------------------------------------------------------------------
// axis_id_unpacker_pkg
// Shared definitions for the TUSER {tid, tkeep} unpacking path.
//  - TUSER field layout (tkeep in the low bits, tid directly above it).
//    This layout must stay identical to the one used by the packing side,
//    otherwise tid and tkeep come back scrambled.
//  - Framing tracker state type used by the unpacker top.
// ----------------------------------------------------------------------------
package axis_id_unpacker_pkg;

    // tkeep occupies TUSER[KEEP_WIDTH-1:0]
    localparam int KEEP_LSB = 0;

    // tid sits immediately above tkeep, so its LSB equals the keep width
    function automatic int tid_lsb(input int keep_width);
        return keep_width;
    endfunction

    // Open/closed packet state of the input-side framing checker
    typedef enum logic {
        FRAME_IDLE   = 1'b0,
        FRAME_IN_PKT = 1'b1
    } frame_state_t;

endpackage

// File: rtl/axis_skid_slice.sv
// ----------------------------------------------------------------------------
// axis_skid_slice
// Generic two-entry AXI-Stream register slice (main register M + skid S).
// Fully registered in both directions: s_ready comes straight from a flop,
// so the upstream ready path is cut. Sustains one beat per cycle while the
// downstream is ready; one beat of latency from input accept to s->m.
// Ports:
//  clk, reset       rising-edge clock, asynchronous active-high reset
//  s_data/s_valid   input payload and valid
//  s_ready          input ready (registered, low while S holds a beat)
//  m_data/m_valid   output payload and valid (held steady while stalled)
//  m_ready          output ready
// ----------------------------------------------------------------------------
module axis_skid_slice #(
    parameter int WIDTH = 75
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] s_data,
    input  logic             s_valid,
    output logic             s_ready,
    output logic [WIDTH-1:0] m_data,
    output logic             m_valid,
    input  logic             m_ready
);

    logic [WIDTH-1:0] main_data;
    logic             main_valid;
    logic [WIDTH-1:0] skid_data;
    logic             skid_valid;
    logic             skid_valid_next;
    logic             ready_q;
    logic             s_accept;
    logic             main_free;

    assign s_accept  = s_valid & ready_q;
    // M can take a new beat when it is empty or is being drained this cycle
    assign main_free = !main_valid | m_ready;

    // S empties whenever M is free (its beat moves up); it only fills when
    // a beat arrives while M is stalled. Input is never accepted while S is
    // full, so the two cases cannot collide.
    always_comb begin
        skid_valid_next = skid_valid;
        if (main_free) begin
            skid_valid_next = 1'b0;
        end else if (s_accept) begin
            skid_valid_next = 1'b1;
        end
    end

    // Register update; ready is the registered inverse of next-cycle S.valid
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            main_data  <= '0;
            main_valid <= 1'b0;
            skid_data  <= '0;
            skid_valid <= 1'b0;
            ready_q    <= 1'b0;
        end else begin
            if (main_free) begin
                if (skid_valid) begin
                    main_data  <= skid_data;
                    main_valid <= 1'b1;
                end else if (s_accept) begin
                    main_data  <= s_data;
                    main_valid <= 1'b1;
                end else begin
                    main_valid <= 1'b0;
                end
            end else if (s_accept) begin
                skid_data <= s_data;
            end
            skid_valid <= skid_valid_next;
            ready_q    <= !skid_valid_next;
        end
    end

    assign s_ready = ready_q;
    assign m_data  = main_data;
    assign m_valid = main_valid;

endmodule

// File: rtl/axis_id_unpacker.sv
// ----------------------------------------------------------------------------
// axis_id_unpacker
// Receive-side inverse of the tid/tkeep-into-tuser packing step. The incoming
// tuser is split back into tid (upper bits) and tkeep (lower bits) after a
// registered skid slice. Input framing is checked on every accepted beat and
// delivered packets are counted on the output side.
// Ports:
//  clk, reset        rising-edge clock, asynchronous active-high reset
//  s_axis_*          input stream: tdata, tuser = {tid, tkeep}, tlast, tvalid,
//                    tready (registered)
//  m_axis_*          output stream: tdata, tid, tkeep, tlast, tvalid, tready
//  err_clear         clears the sticky error flags (a same-cycle error wins)
//  err_tid_change    sticky: tid changed inside an open packet
//  err_keep          sticky: partial tkeep on a non-last beat, or empty tkeep
//                    on a last beat
//  pkt_count         wrapping count of tlast handshakes on the output side
// ----------------------------------------------------------------------------
module axis_id_unpacker
    import axis_id_unpacker_pkg::*;
#(
    parameter int DATA_WIDTH  = 64,
    parameter int TID_WIDTH   = 2,
    parameter int KEEP_WIDTH  = DATA_WIDTH / 8,
    parameter int TUSER_WIDTH = TID_WIDTH + KEEP_WIDTH,
    parameter int CNT_WIDTH   = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [DATA_WIDTH-1:0]  s_axis_tdata,
    input  logic [TUSER_WIDTH-1:0] s_axis_tuser,
    input  logic                   s_axis_tlast,
    input  logic                   s_axis_tvalid,
    output logic                   s_axis_tready,
    output logic [DATA_WIDTH-1:0]  m_axis_tdata,
    output logic [TID_WIDTH-1:0]   m_axis_tid,
    output logic [KEEP_WIDTH-1:0]  m_axis_tkeep,
    output logic                   m_axis_tlast,
    output logic                   m_axis_tvalid,
    input  logic                   m_axis_tready,
    input  logic                   err_clear,
    output logic                   err_tid_change,
    output logic                   err_keep,
    output logic [CNT_WIDTH-1:0]   pkt_count
);

    localparam int TID_LSB     = tid_lsb(KEEP_WIDTH);
    localparam int SLICE_WIDTH = DATA_WIDTH + TUSER_WIDTH + 1;

    logic [SLICE_WIDTH-1:0] slice_in;
    logic [SLICE_WIDTH-1:0] slice_out;
    logic                   s_accept;
    logic [TID_WIDTH-1:0]   in_tid;
    logic [KEEP_WIDTH-1:0]  in_keep;
    logic [TID_WIDTH-1:0]   cur_tid;
    frame_state_t           frame_state;
    frame_state_t           frame_next;
    logic                   tid_change_evt;
    logic                   keep_evt;

    // The whole beat travels through the slice untouched; the split into
    // tid/tkeep on the output side is pure bit slicing.
    assign slice_in = {s_axis_tlast, s_axis_tuser, s_axis_tdata};

    axis_skid_slice #(
        .WIDTH (SLICE_WIDTH)
    ) u_slice (
        .clk     (clk),
        .reset   (reset),
        .s_data  (slice_in),
        .s_valid (s_axis_tvalid),
        .s_ready (s_axis_tready),
        .m_data  (slice_out),
        .m_valid (m_axis_tvalid),
        .m_ready (m_axis_tready)
    );

    assign m_axis_tdata = slice_out[DATA_WIDTH-1:0];
    assign m_axis_tkeep = slice_out[DATA_WIDTH + KEEP_LSB +: KEEP_WIDTH];
    assign m_axis_tid   = slice_out[DATA_WIDTH + TID_LSB +: TID_WIDTH];
    assign m_axis_tlast = slice_out[SLICE_WIDTH-1];

    assign s_accept = s_axis_tvalid & s_axis_tready;
    assign in_tid   = s_axis_tuser[TID_LSB +: TID_WIDTH];
    assign in_keep  = s_axis_tuser[KEEP_LSB +: KEEP_WIDTH];

    // Framing state register; reset closes any open packet
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frame_state <= FRAME_IDLE;
        end else begin
            frame_state <= frame_next;
        end
    end

    // Framing checks on accepted input beats. The error events only flag;
    // packet boundaries are always taken from tlast.
    always_comb begin
        frame_next     = frame_state;
        tid_change_evt = 1'b0;
        keep_evt       = 1'b0;
        if (s_accept) begin
            if (frame_state == FRAME_IN_PKT && in_tid != cur_tid) begin
                tid_change_evt = 1'b1;
            end
            if (!s_axis_tlast && in_keep != '1) begin
                keep_evt = 1'b1;
            end
            if (s_axis_tlast && in_keep == '0) begin
                keep_evt = 1'b1;
            end
            frame_next = s_axis_tlast ? FRAME_IDLE : FRAME_IN_PKT;
        end
    end

    // The packet's tid is latched on its first beat only
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur_tid <= '0;
        end else if (s_accept && frame_state == FRAME_IDLE) begin
            cur_tid <= in_tid;
        end
    end

    // Sticky error flags; a new event in the clearing cycle takes priority
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_tid_change <= 1'b0;
            err_keep       <= 1'b0;
        end else begin
            if (tid_change_evt) begin
                err_tid_change <= 1'b1;
            end else if (err_clear) begin
                err_tid_change <= 1'b0;
            end
            if (keep_evt) begin
                err_keep <= 1'b1;
            end else if (err_clear) begin
                err_keep <= 1'b0;
            end
        end
    end

    // Delivered-packet counter, free-running and wrapping
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pkt_count <= '0;
        end else if (m_axis_tvalid && m_axis_tready && m_axis_tlast) begin
            pkt_count <= pkt_count + CNT_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_axis_id_unpacker.sv
// ----------------------------------------------------------------------------
// tb_axis_id_unpacker
// Directed bench for axis_id_unpacker (DATA_WIDTH=64, TID_WIDTH=2). A second
// instance built with CNT_WIDTH=4 shares the inputs to exercise counter wrap.
// A background monitor compares every valid output beat against a queue of
// accepted input beats.
// ----------------------------------------------------------------------------
module tb_axis_id_unpacker;

    localparam int DW = 64;
    localparam int TW = 2;
    localparam int KW = 8;
    localparam int UW = TW + KW;
    localparam int BW = DW + UW + 1;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [DW-1:0] s_axis_tdata;
    logic [UW-1:0] s_axis_tuser;
    logic          s_axis_tlast;
    logic          s_axis_tvalid;
    logic          s_axis_tready;
    logic [DW-1:0] m_axis_tdata;
    logic [TW-1:0] m_axis_tid;
    logic [KW-1:0] m_axis_tkeep;
    logic          m_axis_tlast;
    logic          m_axis_tvalid;
    logic          m_axis_tready;
    logic          err_clear;
    logic          err_tid_change;
    logic          err_keep;
    logic [31:0]   pkt_count;

    logic          s4_tready;
    logic [DW-1:0] m4_tdata;
    logic [TW-1:0] m4_tid;
    logic [KW-1:0] m4_tkeep;
    logic          m4_tlast;
    logic          m4_tvalid;
    logic          err4_tid_change;
    logic          err4_keep;
    logic [3:0]    pkt4_count;

    int            vec_count = 0;
    int            err_count = 0;
    logic [BW-1:0] exp_q[$];
    int            w_main;
    int            w_fork;

    always #5 clk = ~clk;

    axis_id_unpacker #(
        .DATA_WIDTH (DW),
        .TID_WIDTH  (TW),
        .CNT_WIDTH  (32)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .s_axis_tdata   (s_axis_tdata),
        .s_axis_tuser   (s_axis_tuser),
        .s_axis_tlast   (s_axis_tlast),
        .s_axis_tvalid  (s_axis_tvalid),
        .s_axis_tready  (s_axis_tready),
        .m_axis_tdata   (m_axis_tdata),
        .m_axis_tid     (m_axis_tid),
        .m_axis_tkeep   (m_axis_tkeep),
        .m_axis_tlast   (m_axis_tlast),
        .m_axis_tvalid  (m_axis_tvalid),
        .m_axis_tready  (m_axis_tready),
        .err_clear      (err_clear),
        .err_tid_change (err_tid_change),
        .err_keep       (err_keep),
        .pkt_count      (pkt_count)
    );

    axis_id_unpacker #(
        .DATA_WIDTH (DW),
        .TID_WIDTH  (TW),
        .CNT_WIDTH  (4)
    ) dut4 (
        .clk            (clk),
        .reset          (reset),
        .s_axis_tdata   (s_axis_tdata),
        .s_axis_tuser   (s_axis_tuser),
        .s_axis_tlast   (s_axis_tlast),
        .s_axis_tvalid  (s_axis_tvalid),
        .s_axis_tready  (s4_tready),
        .m_axis_tdata   (m4_tdata),
        .m_axis_tid     (m4_tid),
        .m_axis_tkeep   (m4_tkeep),
        .m_axis_tlast   (m4_tlast),
        .m_axis_tvalid  (m4_tvalid),
        .m_axis_tready  (m_axis_tready),
        .err_clear      (err_clear),
        .err_tid_change (err4_tid_change),
        .err_keep       (err4_keep),
        .pkt_count      (pkt4_count)
    );

    task automatic checkOutput(input string tag, input logic [127:0] observed,
                               input logic [127:0] expected);
        vec_count++;
        if (observed !== expected) begin
            err_count++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // Drives one beat starting at a negedge, waits (bounded) for ready and
    // returns at the negedge after the accepting edge with valid dropped.
    task automatic applyStimulus(input logic [TW-1:0] tid, input logic [KW-1:0] keep,
                                 input logic [DW-1:0] data, input logic last,
                                 output int waited);
        s_axis_tvalid = 1'b1;
        s_axis_tuser  = {tid, keep};
        s_axis_tdata  = data;
        s_axis_tlast  = last;
        waited = 0;
        while (s_axis_tready !== 1'b1 && waited < 40) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= 40) begin
            checkOutput("accept_timeout", s_axis_tready, 1);
        end else begin
            @(negedge clk);
            exp_q.push_back({last, tid, keep, data});
        end
        s_axis_tvalid = 1'b0;
    endtask

    task automatic idleCycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clearPulse();
        err_clear = 1'b1;
        @(negedge clk);
        err_clear = 1'b0;
    endtask

    // Output monitor: sampled mid-low-phase, after all negedge drives settle
    initial begin
        logic [BW-1:0] front;
        forever begin
            @(negedge clk);
            #2;
            if (!reset && m_axis_tvalid) begin
                if (exp_q.size() == 0) begin
                    checkOutput("unexpected_beat", m_axis_tvalid, 0);
                end else begin
                    front = exp_q[0];
                    checkOutput("beat", {m_axis_tlast, m_axis_tid, m_axis_tkeep, m_axis_tdata}, front);
                    if (m_axis_tready) begin
                        void'(exp_q.pop_front());
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        s_axis_tdata  = '0;
        s_axis_tuser  = '0;
        s_axis_tlast  = 1'b0;
        s_axis_tvalid = 1'b0;
        m_axis_tready = 1'b0;
        err_clear     = 1'b0;
        reset         = 1'b1;

        // Reset values
        idleCycles(2);
        checkOutput("rst_tvalid", m_axis_tvalid, 0);
        checkOutput("rst_tready", s_axis_tready, 0);
        checkOutput("rst_tdata", m_axis_tdata, 0);
        checkOutput("rst_tid", m_axis_tid, 0);
        checkOutput("rst_tlast", m_axis_tlast, 0);
        checkOutput("rst_err_tid", err_tid_change, 0);
        checkOutput("rst_err_keep", err_keep, 0);
        checkOutput("rst_pkt", pkt_count, 0);
        reset = 1'b0;
        #1;
        checkOutput("ready_low_after_release", s_axis_tready, 0);
        @(negedge clk);
        checkOutput("ready_first_edge", s_axis_tready, 1);
        m_axis_tready = 1'b1;

        // Single beat split
        applyStimulus(2'd2, 8'hFF, 64'hDEAD_BEEF_0123_4567, 1'b1, w_main);
        checkOutput("t1_valid", m_axis_tvalid, 1);
        checkOutput("t1_tid", m_axis_tid, 2);
        checkOutput("t1_keep", m_axis_tkeep, 8'hFF);
        checkOutput("t1_data", m_axis_tdata, 64'hDEAD_BEEF_0123_4567);
        checkOutput("t1_last", m_axis_tlast, 1);
        idleCycles(1);
        checkOutput("t1_pkt", pkt_count, 1);
        checkOutput("t1_err_tid", err_tid_change, 0);
        checkOutput("t1_err_keep", err_keep, 0);
        checkOutput("t1_valid_off", m_axis_tvalid, 0);

        // Streaming 16 beats, one per cycle
        for (int i = 0; i < 16; i++) begin
            applyStimulus(2'd0, 8'hFF, {32'hA5A5_0000, i}, (i == 15), w_main);
            checkOutput("stream_wait", w_main, 0);
            checkOutput("stream_ready", s_axis_tready, 1);
            checkOutput("stream_latency", m_axis_tvalid, 1);
            checkOutput("stream_data", m_axis_tdata, {32'hA5A5_0000, i});
        end
        idleCycles(1);
        checkOutput("stream_pkt", pkt_count, 2);

        // Backpressure for 3 cycles mid-stream
        for (int i = 0; i < 2; i++) begin
            applyStimulus(2'd1, 8'hFF, {32'hB0B0_0000, i}, 1'b0, w_main);
        end
        m_axis_tready = 1'b0;
        applyStimulus(2'd1, 8'hFF, {32'hB0B0_0000, 32'd2}, 1'b0, w_main);
        checkOutput("bp_ready_drop", s_axis_tready, 0);
        checkOutput("bp_hold_data", m_axis_tdata, {32'hB0B0_0000, 32'd1});
        fork
            begin
                @(negedge clk);
                checkOutput("bp_hold_steady", m_axis_tdata, {32'hB0B0_0000, 32'd1});
                checkOutput("bp_ready_low", s_axis_tready, 0);
                @(negedge clk);
                m_axis_tready = 1'b1;
            end
            begin
                for (int i = 3; i < 8; i++) begin
                    applyStimulus(2'd1, 8'hFF, {32'hB0B0_0000, i}, (i == 7), w_fork);
                end
            end
        join
        idleCycles(3);
        checkOutput("bp_drained", exp_q.size(), 0);
        checkOutput("bp_pkt", pkt_count, 3);

        // tid change inside a packet, then clear; set beats clear
        applyStimulus(2'd1, 8'hFF, 64'h4000_0001, 1'b0, w_main);
        applyStimulus(2'd1, 8'hFF, 64'h4000_0002, 1'b0, w_main);
        checkOutput("tid_same_ok", err_tid_change, 0);
        applyStimulus(2'd3, 8'hFF, 64'h4000_0003, 1'b1, w_main);
        checkOutput("tid_change_set", err_tid_change, 1);
        checkOutput("tid_keep_ok", err_keep, 0);
        clearPulse();
        checkOutput("tid_cleared", err_tid_change, 0);
        applyStimulus(2'd0, 8'hFF, 64'h4100_0001, 1'b0, w_main);
        err_clear = 1'b1;
        applyStimulus(2'd2, 8'hFF, 64'h4100_0002, 1'b1, w_main);
        err_clear = 1'b0;
        checkOutput("set_wins", err_tid_change, 1);
        clearPulse();
        checkOutput("set_wins_cleared", err_tid_change, 0);
        idleCycles(1);
        checkOutput("tid_pkt", pkt_count, 5);

        // tkeep rules
        applyStimulus(2'd0, 8'h0F, 64'h5000_0001, 1'b0, w_main);
        checkOutput("keep_partial_mid", err_keep, 1);
        applyStimulus(2'd0, 8'hFF, 64'h5000_0002, 1'b1, w_main);
        clearPulse();
        checkOutput("keep_cleared", err_keep, 0);
        applyStimulus(2'd0, 8'h00, 64'h5000_0003, 1'b1, w_main);
        checkOutput("keep_zero_last", err_keep, 1);
        clearPulse();
        applyStimulus(2'd0, 8'h01, 64'h5000_0004, 1'b1, w_main);
        checkOutput("keep_one_last", err_keep, 0);
        checkOutput("keep_tid_ok", err_tid_change, 0);
        idleCycles(1);
        checkOutput("pkt_after_clears", pkt_count, 8);

        // Reset with S full and a packet open
        m_axis_tready = 1'b0;
        applyStimulus(2'd1, 8'hFF, 64'h6000_0001, 1'b0, w_main);
        applyStimulus(2'd2, 8'hFF, 64'h6000_0002, 1'b0, w_main);
        checkOutput("pre_rst_err", err_tid_change, 1);
        checkOutput("pre_rst_ready", s_axis_tready, 0);
        reset = 1'b1;
        #1;
        exp_q.delete();
        checkOutput("rst6_valid", m_axis_tvalid, 0);
        checkOutput("rst6_ready", s_axis_tready, 0);
        checkOutput("rst6_data", m_axis_tdata, 0);
        checkOutput("rst6_err_tid", err_tid_change, 0);
        checkOutput("rst6_pkt", pkt_count, 0);
        m_axis_tready = 1'b1;
        idleCycles(2);
        reset = 1'b0;
        @(negedge clk);
        applyStimulus(2'd3, 8'hFF, 64'h7000_0001, 1'b1, w_main);
        idleCycles(1);
        checkOutput("post_rst_pkt", pkt_count, 1);
        checkOutput("post_rst_err_tid", err_tid_change, 0);
        checkOutput("post_rst_drained", exp_q.size(), 0);

        // Counter wrap on the 4-bit instance
        for (int i = 0; i < 14; i++) begin
            applyStimulus(i[1:0], 8'hFF, {32'h8000_0000, i}, 1'b1, w_main);
        end
        idleCycles(1);
        checkOutput("wrap_preload", pkt4_count, 4'hF);
        checkOutput("wrap_main_15", pkt_count, 15);
        applyStimulus(2'd0, 8'hFF, 64'h8000_00FF, 1'b1, w_main);
        idleCycles(1);
        checkOutput("wrap_zero", pkt4_count, 4'h0);
        checkOutput("wrap_main_16", pkt_count, 16);

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
        $finish;
    end

endmodule
